// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for fetch/load/store with a registered req/gnt handshake.
// Build option MEM_ARB_RR_EN: round-robin arbitration instead of fixed str > ldr > fetch priority.
module mem_port_arbiter #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [AWIDTH-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_vld,
    input  logic              ldr_req,
    input  logic [AWIDTH-1:0] ldr_addr,
    output logic              ldr_gnt,
    output logic              ldr_vld,
    input  logic              str_req,
    input  logic [AWIDTH-1:0] str_addr,
    input  logic [DWIDTH-1:0] str_wdata,
    output logic              str_gnt,
    output logic              str_done,
    output logic [DWIDTH-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_wdata,
    input  logic [DWIDTH-1:0] ram_rdata,
    output logic              busy
);

    // state   | meaning
    // IDLE    | no access in flight; arbitrate on any req
    // ACCESS  | RAM samples the registered strobe this cycle
    // RD_WAIT | counting down read latency, capture rdata at zero
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    // Requesters are kept one-hot: bit0 fetch, bit1 ldr, bit2 str.
    localparam logic [2:0] SEL_FETCH = 3'b001;
    localparam logic [2:0] SEL_LDR   = 3'b010;
    localparam logic [2:0] SEL_STR   = 3'b100;
    localparam logic [1:0] CNT_INIT  = 2'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [2:0]        sel_q, sel_d;
    logic [2:0]        gnt_q, gnt_d;
    logic [2:0]        vld_q, vld_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic              busy_q, busy_d;
    logic [AWIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DWIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic [2:0]        req;
    logic [2:0]        win;

    assign req = {str_req, ldr_req, fetch_req};

`ifdef MEM_ARB_RR_EN
    logic [2:0] ptr_q, ptr_d;

    // Search starts just after the last granted requester.
    always_comb begin
        win = 3'b000;
        case (ptr_q)
            SEL_LDR: win = req[2] ? SEL_STR : req[0] ? SEL_FETCH : req[1] ? SEL_LDR : 3'b000;
            SEL_STR: win = req[0] ? SEL_FETCH : req[1] ? SEL_LDR : req[2] ? SEL_STR : 3'b000;
            default: win = req[1] ? SEL_LDR : req[2] ? SEL_STR : req[0] ? SEL_FETCH : 3'b000;
        endcase
    end
`else
    always_comb begin
        win = req[2] ? SEL_STR : req[1] ? SEL_LDR : req[0] ? SEL_FETCH : 3'b000;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        gnt_d       = 3'b000;
        vld_d       = 3'b000;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rdata_d     = rdata_q;
`ifdef MEM_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    sel_d      = win;
                    gnt_d      = win;
                    ram_en_d   = 1'b1;
                    ram_addr_d = win[2] ? str_addr : (win[1] ? ldr_addr : fetch_addr);
                    if (win[2]) begin
                        ram_we_d    = 1'b1;
                        ram_wdata_d = str_wdata;
                    end
`ifdef MEM_ARB_RR_EN
                    ptr_d      = win;
`endif
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (sel_q[2]) begin
                    vld_d   = SEL_STR;
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = ram_rdata;
                    vld_d   = sel_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            sel_q       <= 3'b000;
            gnt_q       <= 3'b000;
            vld_q       <= 3'b000;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            vld_q       <= vld_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            busy_q      <= busy_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SEL_FETCH;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign fetch_gnt = gnt_q[0];
    assign ldr_gnt   = gnt_q[1];
    assign str_gnt   = gnt_q[2];
    assign fetch_vld = vld_q[0];
    assign ldr_vld   = vld_q[1];
    assign str_done  = vld_q[2];
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two lanes (RD_LAT 1 and 3), each with its own RAM and transaction model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MEM_ARB_RR_EN
    localparam int EXP3 = 231;
    localparam int EXP6 = 212121;
`else
    localparam int EXP3 = 321;
    localparam int EXP6 = 222222;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ram_init(input logic [7:0] a);
        if (a == 8'h05) return 16'h1A2B;
        if (a == 8'h20) return 16'h0042;
        return {a, ~a} ^ 16'h3C5A;
    endfunction

    // Requester index: 0 fetch, 1 ldr, 2 str.
    function automatic int pick(input logic [2:0] r, input int last);
`ifdef MEM_ARB_RR_EN
        for (int k = 1; k <= 3; k++) if (r[(last + k) % 3]) return (last + k) % 3;
`else
        for (int k = 2; k >= 0; k--) if (r[k]) return k;
`endif
        return last;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        rst_n;
        logic        fetch_req, ldr_req, str_req;
        logic [7:0]  fetch_addr, ldr_addr, str_addr;
        logic [15:0] str_wdata;
        logic        fetch_gnt, fetch_vld, ldr_gnt, ldr_vld, str_gnt, str_done;
        logic [15:0] rdata, ram_wdata, ram_rdata;
        logic        ram_en, ram_we, busy;
        logic [7:0]  ram_addr;

        mem_port_arbiter #(.DWIDTH(16), .AWIDTH(8), .RD_LAT(LAT)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_vld(fetch_vld),
            .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_gnt(ldr_gnt), .ldr_vld(ldr_vld),
            .str_req(str_req), .str_addr(str_addr), .str_wdata(str_wdata),
            .str_gnt(str_gnt), .str_done(str_done), .rdata(rdata),
            .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
            .ram_rdata(ram_rdata), .busy(busy)
        );

        // RAM: read data is valid LAT cycles after the access cycle, junk otherwise.
        logic [15:0] ram [256];
        bit          ram_wr [256];
        logic [15:0] pipe [LAT];
        assign ram_rdata = pipe[LAT-1];
        always @(posedge clk) begin
            if (ram_en && ram_we) begin
                ram[ram_addr]    <= ram_wdata;
                ram_wr[ram_addr] <= 1'b1;
            end
            pipe[0] <= (ram_en && !ram_we) ? (ram_wr[ram_addr] ? ram[ram_addr] : ram_init(ram_addr))
                                           : 16'($urandom);
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end

        // Transaction model: expected outputs for the next cycle, keyed by cycle number.
        logic [15:0] mmem [256];
        bit          mwr [256];
        logic [2:0]  pend = '0;
        logic [2:0]  cont = '0;
        logic [7:0]  paddr [3] = '{default: 8'h00};
        logic [15:0] pwd = '0;
        bit          rnd_mode = 1'b0;
        int          cyc = 0, idle_from = 0, ev_cyc = -1, ev_who = 0, last_ptr = 0;
        logic [15:0] ev_data = '0;
        logic [2:0]  e_gnt, e_vld;
        logic        e_en, e_we, e_busy;
        logic [7:0]  e_addr;
        logic [15:0] e_wdata, e_rdata;
        int          gq [$];
        int          gnt_cyc = 0, vld_cyc = 0;
        bit          lane_done = 1'b0;

        function automatic string tg(input string s);
            return $sformatf("L%0d.%s", g, s);
        endfunction

        function automatic int seq_code(input int n);
            int c = 0;
            for (int i = 0; i < n; i++) c = c * 10 + ((i < gq.size()) ? gq[i] + 1 : 0);
            return c;
        endfunction

        task automatic model_reset();
            pend = '0; cont = '0; idle_from = 0; ev_cyc = -1; last_ptr = 0;
            e_gnt = '0; e_vld = '0; e_en = 1'b0; e_we = 1'b0; e_busy = 1'b0;
            e_addr = '0; e_wdata = '0; e_rdata = '0;
        endtask

        task automatic drive();
            fetch_req = pend[0]; ldr_req = pend[1]; str_req = pend[2];
            fetch_addr = paddr[0]; ldr_addr = paddr[1]; str_addr = paddr[2];
            str_wdata = pwd;
        endtask

        task automatic issue(input int who, input logic [7:0] a, input logic [15:0] wd);
            pend[who] = 1'b1;
            paddr[who] = a;
            if (who == 2) pwd = wd;
        endtask

        task automatic step();
            logic [2:0] g_obs, v_obs;
            int w;
            @(negedge clk);
            cyc++;
            g_obs = {str_gnt, ldr_gnt, fetch_gnt};
            v_obs = {str_done, ldr_vld, fetch_vld};
            chk(tg("gnt"), 32'(g_obs), 32'(e_gnt));
            chk(tg("vld"), 32'(v_obs), 32'(e_vld));
            chk(tg("en_we"), 32'({ram_en, ram_we}), 32'({e_en, e_we}));
            if (e_en) chk(tg("ram_addr"), 32'(ram_addr), 32'(e_addr));
            if (e_we) chk(tg("ram_wdata"), 32'(ram_wdata), 32'(e_wdata));
            chk(tg("rdata"), 32'(rdata), 32'(e_rdata));
            chk(tg("busy"), 32'(busy), 32'(e_busy));
            if (g_obs != 3'b000) gnt_cyc = cyc;
            if (v_obs != 3'b000) vld_cyc = cyc;
            for (int i = 0; i < 3; i++) begin
                if (g_obs[i]) begin
                    gq.push_back(i);
                    pend[i] = 1'b0;
                end else if (!pend[i] && (cont[i] || (rnd_mode && $urandom_range(3) == 0))) begin
                    pend[i] = 1'b1;
                    if (rnd_mode) begin
                        paddr[i] = 8'($urandom_range(15));
                        if (i == 2) pwd = 16'($urandom);
                    end
                end
            end
            drive();
            e_gnt = '0; e_vld = '0; e_en = 1'b0; e_we = 1'b0;
            if (cyc >= idle_from && pend != 3'b000) begin
                w = pick(pend, last_ptr);
                last_ptr = w;
                e_gnt[w] = 1'b1;
                e_en = 1'b1;
                e_addr = paddr[w];
                ev_who = w;
                if (w == 2) begin
                    e_we = 1'b1;
                    e_wdata = pwd;
                    mmem[paddr[2]] = pwd;
                    mwr[paddr[2]] = 1'b1;
                    ev_cyc = cyc + 2;
                    idle_from = cyc + 2;
                end else begin
                    ev_data = mwr[paddr[w]] ? mmem[paddr[w]] : ram_init(paddr[w]);
                    ev_cyc = cyc + LAT + 2;
                    idle_from = cyc + LAT + 2;
                end
            end
            if (ev_cyc == cyc + 1) begin
                e_vld[ev_who] = 1'b1;
                if (ev_who != 2) e_rdata = ev_data;
                ev_cyc = -1;
            end
            e_busy = (cyc + 1 < idle_from);
        endtask

        task automatic run_until_idle();
            int n = 0;
            while ((pend != 3'b000 || cyc + 1 < idle_from || ev_cyc >= 0) && n < 200) begin
                step();
                n++;
            end
            step();
            chk(tg("idle_wait"), 32'(n < 200), 32'd1);
        endtask

        task automatic do_reset();
            rst_n = 1'b0;
            #1;
            chk(tg("rst_ctl"), 32'({fetch_gnt, fetch_vld, ldr_gnt, ldr_vld, str_gnt, str_done,
                                    ram_en, ram_we, busy}), 32'd0);
            chk(tg("rst_ram"), 32'({ram_addr, ram_wdata}), 32'd0);
            chk(tg("rst_rdata"), 32'(rdata), 32'd0);
            model_reset();
            drive();
            step();
            step();
            rst_n = 1'b1;
        endtask

        initial begin
            int n;
            rst_n = 1'b1;
            model_reset();
            drive();
            #2;
            do_reset();

            // fetch from a preloaded word
            issue(0, 8'h05, 16'h0000);
            run_until_idle();
            chk(tg("t1_rdata"), 32'(rdata), 32'h1A2B);
            chk(tg("t1_lat"), 32'(vld_cyc - gnt_cyc), 32'(LAT + 1));

            // store then load back the same word
            issue(2, 8'h10, 16'hBEEF);
            run_until_idle();
            chk(tg("t2_done_lat"), 32'(vld_cyc - gnt_cyc), 32'd1);
            issue(1, 8'h10, 16'h0000);
            run_until_idle();
            chk(tg("t2_rdata"), 32'(rdata), 32'hBEEF);

            // all three requesters at once
            do_reset();
            gq.delete();
            issue(2, 8'h11, 16'h1234);
            issue(1, 8'h05, 16'h0000);
            issue(0, 8'h20, 16'h0000);
            run_until_idle();
            chk(tg("t3_order"), 32'(seq_code(3)), 32'(EXP3));

            // load latency
            issue(1, 8'h20, 16'h0000);
            run_until_idle();
            chk(tg("t4_rdata"), 32'(rdata), 32'h0042);
            chk(tg("t4_lat"), 32'(vld_cyc - gnt_cyc), 32'(LAT + 1));

            // reset while a fetch waits for read data
            issue(0, 8'h33, 16'h0000);
            n = 0;
            while (!fetch_gnt && n < 20) begin
                step();
                n++;
            end
            chk(tg("t5_gnt_wait"), 32'(n < 20), 32'd1);
            step();
            #2;
            do_reset();
            run_until_idle();
            issue(0, 8'h44, 16'h0000);
            run_until_idle();
            chk(tg("t5_rdata"), 32'(rdata), 32'(ram_init(8'h44)));

            // fetch and ldr re-raised after every grant
            do_reset();
            gq.delete();
            issue(0, 8'h06, 16'h0000);
            issue(1, 8'h07, 16'h0000);
            cont = 3'b011;
            n = 0;
            while (gq.size() < 6 && n < 200) begin
                step();
                n++;
            end
            cont = 3'b000;
            run_until_idle();
            chk(tg("t6_order"), 32'(seq_code(6)), 32'(EXP6));

            // random traffic on a small address window
            rnd_mode = 1'b1;
            repeat (600) step();
            rnd_mode = 1'b0;
            run_until_idle();
            lane_done = 1'b1;
        end
    end

    initial begin
        int t = 0;
        while (!(lane[0].lane_done && lane[1].lane_done) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("lanes_finished", 32'(t < 20000), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
